// File: rtl/fetch.sv
// Instruction fetch stage.
//
// Issues one instruction-memory read at a time at the current PC and hands the
// returned word to decode through the IF/ID register (if_id_instrucao /
// if_id_proximopc). The stage handles a load-use stall from forwarding and
// redirects from decode. A redirect applies after the delay-slot instruction
// has been delivered.
//
// Ports
//   clock            in   single clock, rising edge
//   reset            in   asynchronous, active-low
//   fw_if_id_stall   in   freezes PC and IF/ID; redirect inputs ignored
//   id_if_selfontepc in   1 = redirect using id_if_seltipopc
//   id_if_seltipopc  in   00 branch, 01 jump index, 10 register, 11 sequential
//   id_if_pcimd2ext  in   branch target
//   id_if_pcindex    in   J/JAL target
//   id_if_rega       in   JR/JALR target
//   if_mc_en         out  instruction-memory read request
//   if_mc_addr       out  read address (current PC)
//   mc_if_ready      in   mc_if_data valid this cycle (only while if_mc_en=1)
//   mc_if_data       in   instruction word
//   if_id_instrucao  out  IF/ID instruction
//   if_id_proximopc  out  IF/ID delivered address + 4 (0 for a bubble)
//
// State | meaning
// IDLE  | first cycle after reset, no request outstanding
// WAIT  | request at pc outstanding, waiting for mc_if_ready
// HOLD  | word returned during a stall, kept in hold_buf until the stall drops

module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fw_if_id_stall,
    input  logic        id_if_selfontepc,
    input  logic [1:0]  id_if_seltipopc,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_pcindex,
    input  logic [31:0] id_if_rega,
    output logic        if_mc_en,
    output logic [31:0] if_mc_addr,
    input  logic        mc_if_ready,
    input  logic [31:0] mc_if_data,
    output logic [31:0] if_id_instrucao,
    output logic [31:0] if_id_proximopc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic        pend;
    logic [31:0] pend_tgt;

    logic [31:0] pc_seq;
    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] next_pc;
    logic        accept;
    logic [31:0] fetch_word;

    always_comb begin
        pc_seq = pc + 32'd4;
        redir  = id_if_selfontepc && (id_if_seltipopc != 2'b11);
        case (id_if_seltipopc)
            2'b00:   redir_tgt = id_if_pcimd2ext;
            2'b01:   redir_tgt = id_if_pcindex;
            2'b10:   redir_tgt = id_if_rega;
            default: redir_tgt = pc_seq;
        endcase
        // A captured redirect has priority: the delay slot it was waiting
        // for is the instruction being delivered now.
        if (pend) begin
            next_pc = pend_tgt;
        end else if (redir) begin
            next_pc = redir_tgt;
        end else begin
            next_pc = pc_seq;
        end
        accept = !fw_if_id_stall &&
                 (((state == S_WAIT) && mc_if_ready) || (state == S_HOLD));
        fetch_word = (state == S_HOLD) ? hold_buf : mc_if_data;
    end

    assign if_mc_en   = (state == S_WAIT);
    assign if_mc_addr = pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            pc              <= RESET_PC;
            hold_buf        <= 32'd0;
            pend            <= 1'b0;
            pend_tgt        <= 32'd0;
            if_id_instrucao <= NOP_WORD;
            if_id_proximopc <= 32'd0;
        end else begin
            case (state)
                S_IDLE: state <= S_WAIT;
                S_WAIT: begin
                    if (mc_if_ready && fw_if_id_stall) begin
                        hold_buf <= mc_if_data;
                        state    <= S_HOLD;
                    end else if (!mc_if_ready && !fw_if_id_stall) begin
                        if_id_instrucao <= NOP_WORD;
                        if_id_proximopc <= 32'd0;
                    end
                end
                S_HOLD: begin
                    if (!fw_if_id_stall) begin
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                if_id_instrucao <= fetch_word;
                if_id_proximopc <= pc_seq;
                pc              <= next_pc;
                pend            <= 1'b0;
            end else if (!fw_if_id_stall && redir && !pend) begin
                // Delay slot not delivered yet: remember where to go after it.
                pend     <= 1'b1;
                pend_tgt <= redir_tgt;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        selfontepc = 1'b0;
    logic [1:0]  seltipopc = 2'b00;
    logic [31:0] pcimd2ext = '0;
    logic [31:0] pcindex = '0;
    logic [31:0] rega = '0;
    logic        mc_en;
    logic [31:0] mc_addr;
    logic        ready = 1'b0;
    logic [31:0] data = '0;
    logic [31:0] instrucao;
    logic [31:0] proximopc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
        .clock            (clock),
        .reset            (reset),
        .fw_if_id_stall   (stall),
        .id_if_selfontepc (selfontepc),
        .id_if_seltipopc  (seltipopc),
        .id_if_pcimd2ext  (pcimd2ext),
        .id_if_pcindex    (pcindex),
        .id_if_rega       (rega),
        .if_mc_en         (mc_en),
        .if_mc_addr       (mc_addr),
        .mc_if_ready      (ready),
        .mc_if_data       (data),
        .if_id_instrucao  (instrucao),
        .if_id_proximopc  (proximopc)
    );

    always #5 clock = ~clock;

    // Behavioural model: a fetcher that has either started or not, may be
    // holding one already-returned word, and owes at most one redirect.
    bit          m_started;
    bit          m_have_buf;
    logic [31:0] m_buf;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_prox;
    logic [31:0] m_pend[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0:   memf = 32'h11;
            32'h4:   memf = 32'h22;
            32'h8:   memf = 32'h33;
            default: memf = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("if_mc_en", {31'd0, mc_en}, {31'd0, (m_started && !m_have_buf)});
        check("if_mc_addr", mc_addr, m_pc);
        check("if_id_instrucao", instrucao, m_instr);
        check("if_id_proximopc", proximopc, m_prox);
    endtask

    task automatic model_reset();
        m_started  = 0;
        m_have_buf = 0;
        m_buf      = '0;
        m_pc       = RPC;
        m_instr    = NOP;
        m_prox     = '0;
        m_pend.delete();
    endtask

    // Called at a falling edge; leaves at the next falling edge after checking.
    task automatic step(input bit rdy, input bit st, input bit sf, input logic [1:0] tp,
                        input logic [31:0] im, input logic [31:0] ix, input logic [31:0] ra);
        logic [31:0] tgt;
        bit          rd;
        ready      = rdy;
        stall      = st;
        selfontepc = sf;
        seltipopc  = tp;
        pcimd2ext  = im;
        pcindex    = ix;
        rega       = ra;
        data       = memf(m_pc);
        rd  = sf && (tp != 2'b11);
        tgt = (tp == 2'b00) ? im : (tp == 2'b01) ? ix : (tp == 2'b10) ? ra : m_pc + 32'd4;
        if (st) begin
            if (m_started && !m_have_buf && rdy) begin
                m_have_buf = 1;
                m_buf      = data;
            end
        end else begin
            if (m_started && (m_have_buf || rdy)) begin
                m_instr = m_have_buf ? m_buf : data;
                m_prox  = m_pc + 32'd4;
                if (m_pend.size() > 0) m_pc = m_pend.pop_front();
                else if (rd)           m_pc = tgt;
                else                   m_pc = m_pc + 32'd4;
                m_have_buf = 0;
            end else begin
                if (m_started) begin
                    m_instr = NOP;
                    m_prox  = '0;
                end
                if (rd && m_pend.size() == 0) m_pend.push_back(tgt);
            end
        end
        m_started = 1;
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    task automatic go(input bit rdy, input bit st);
        step(rdy, st, 1'b0, 2'b11, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        reset_pulse();

        // Back-to-back fetch with zero-wait memory
        go(1, 0);
        check("idle_to_wait_en", {31'd0, mc_en}, 32'd1);
        go(1, 0);
        check("seq_w0", instrucao, 32'h11);  check("seq_p0", proximopc, 32'h4);
        go(1, 0);
        check("seq_w1", instrucao, 32'h22);  check("seq_p1", proximopc, 32'h8);
        go(1, 0);
        check("seq_w2", instrucao, 32'h33);  check("seq_p2", proximopc, 32'hC);

        // Memory ready every third cycle
        reset_pulse();
        go(1, 0);
        for (int k = 0; k < 9; k++) begin
            go(k % 3 == 2, 0);
            if (k == 0) begin
                check("slow_bubble_w", instrucao, NOP);
                check("slow_bubble_p", proximopc, 32'h0);
            end
            if (k == 2) check("slow_w0", instrucao, 32'h11);
            if (k == 3) check("slow_addr1", mc_addr, 32'h4);
            if (k == 5) check("slow_w1", instrucao, 32'h22);
            if (k == 8) check("slow_p2", proximopc, 32'hC);
        end

        // Stall while the word at 0x8 returns
        reset_pulse();
        go(1, 0); go(1, 0); go(1, 0);
        go(1, 1);
        check("hold_en", {31'd0, mc_en}, 32'd0);
        check("hold_frozen", instrucao, 32'h22);
        go(1, 1);
        check("hold_en2", {31'd0, mc_en}, 32'd0);
        go(0, 0);
        check("hold_release_w", instrucao, 32'h33);
        check("hold_release_addr", mc_addr, 32'hC);

        // Branch with delay slot ready immediately
        reset_pulse();
        go(1, 0); go(1, 0); go(1, 0);
        step(1, 0, 1, 2'b00, 32'h100, 32'd0, 32'd0);
        check("br_slot", instrucao, 32'h33);
        check("br_addr", mc_addr, 32'h100);

        // Branch with delay slot late; second redirect ignored
        reset_pulse();
        go(1, 0); go(1, 0); go(1, 0);
        step(0, 0, 1, 2'b00, 32'h100, 32'd0, 32'd0);
        check("brp_bubble", instrucao, NOP);
        check("brp_addr_hold", mc_addr, 32'h8);
        step(0, 0, 1, 2'b00, 32'h300, 32'd0, 32'd0);
        go(1, 0);
        check("brp_slot", instrucao, 32'h33);
        check("brp_addr", mc_addr, 32'h100);

        reset_pulse();
        go(1, 0); go(1, 0); go(1, 0);
        step(0, 0, 1, 2'b10, 32'd0, 32'd0, 32'h200);
        go(0, 0);
        go(1, 0);
        check("jr_addr", mc_addr, 32'h200);

        // Reset asserted during WAIT at 0x40
        reset_pulse();
        go(1, 0);
        step(1, 0, 1, 2'b01, 32'd0, 32'h40, 32'd0);
        go(0, 0);
        check("pre_rst_addr", mc_addr, 32'h40);
        reset = 1'b0;
        #1;
        check("rst_en", {31'd0, mc_en}, 32'd0);
        check("rst_addr", mc_addr, RPC);
        check("rst_instr", instrucao, NOP);
        check("rst_prox", proximopc, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        go(1, 0);
        check("post_rst_addr", mc_addr, RPC);
        check("post_rst_en", {31'd0, mc_en}, 32'd1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_pulse();
            end else begin
                step($urandom_range(0, 99) < 60,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 20,
                     2'($urandom_range(0, 3)),
                     $urandom & 32'hFFFF_FFFC,
                     $urandom & 32'hFFFF_FFFC,
                     $urandom & 32'hFFFF_FFFC);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
